// File: rtl/encode_8b10b_wide_pkg.sv
// ---------------------------------------------------------------------------
// linecode_8b10b_pkg
// Shared 8b/10b definitions: legal K-code bytes, the K28.5 codewords used as
// the substitute for illegal control bytes, and the RD-negative sub-block
// lookup tables used by the lane encoder.
// ---------------------------------------------------------------------------
package linecode_8b10b_pkg;

   localparam logic [7:0] K28_0 = 8'h1C;
   localparam logic [7:0] K28_1 = 8'h3C;
   localparam logic [7:0] K28_2 = 8'h5C;
   localparam logic [7:0] K28_3 = 8'h7C;
   localparam logic [7:0] K28_4 = 8'h9C;
   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K28_6 = 8'hDC;
   localparam logic [7:0] K28_7 = 8'hFC;
   localparam logic [7:0] K23_7 = 8'hF7;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K30_7 = 8'hFE;

   localparam logic [9:0] K28_5_NEG = 10'b0011111010;
   localparam logic [9:0] K28_5_POS = 10'b1100000101;

   // True for the twelve control bytes that have a defined K codeword
   function automatic logic is_legal_k(input logic [7:0] b);
      case (b)
         K28_0, K28_1, K28_2, K28_3, K28_4, K28_5, K28_6, K28_7,
         K23_7, K27_7, K29_7, K30_7: is_legal_k = 1'b1;
         default:                    is_legal_k = 1'b0;
      endcase
   endfunction

   // 5b/6b data table, abcdei, form used when the running disparity is negative
   function automatic logic [5:0] enc_5b6b_neg(input logic [4:0] x);
      case (x)
         5'd0:  enc_5b6b_neg = 6'b100111;
         5'd1:  enc_5b6b_neg = 6'b011101;
         5'd2:  enc_5b6b_neg = 6'b101101;
         5'd3:  enc_5b6b_neg = 6'b110001;
         5'd4:  enc_5b6b_neg = 6'b110101;
         5'd5:  enc_5b6b_neg = 6'b101001;
         5'd6:  enc_5b6b_neg = 6'b011001;
         5'd7:  enc_5b6b_neg = 6'b111000;
         5'd8:  enc_5b6b_neg = 6'b111001;
         5'd9:  enc_5b6b_neg = 6'b100101;
         5'd10: enc_5b6b_neg = 6'b010101;
         5'd11: enc_5b6b_neg = 6'b110100;
         5'd12: enc_5b6b_neg = 6'b001101;
         5'd13: enc_5b6b_neg = 6'b101100;
         5'd14: enc_5b6b_neg = 6'b011100;
         5'd15: enc_5b6b_neg = 6'b010111;
         5'd16: enc_5b6b_neg = 6'b011011;
         5'd17: enc_5b6b_neg = 6'b100011;
         5'd18: enc_5b6b_neg = 6'b010011;
         5'd19: enc_5b6b_neg = 6'b110010;
         5'd20: enc_5b6b_neg = 6'b001011;
         5'd21: enc_5b6b_neg = 6'b101010;
         5'd22: enc_5b6b_neg = 6'b011010;
         5'd23: enc_5b6b_neg = 6'b111010;
         5'd24: enc_5b6b_neg = 6'b110011;
         5'd25: enc_5b6b_neg = 6'b100110;
         5'd26: enc_5b6b_neg = 6'b010110;
         5'd27: enc_5b6b_neg = 6'b110110;
         5'd28: enc_5b6b_neg = 6'b001110;
         5'd29: enc_5b6b_neg = 6'b101110;
         5'd30: enc_5b6b_neg = 6'b011110;
         5'd31: enc_5b6b_neg = 6'b101011;
         default: enc_5b6b_neg = 6'b000000;
      endcase
   endfunction

   // 3b/4b table, fghj, form used when the RD entering the 4b block is negative.
   // K rows differ from data rows; alt7 picks the A7 code for data x.7.
   function automatic logic [3:0] enc_3b4b_neg(input logic [2:0] y, input logic k,
                                               input logic alt7);
      case ({k, y})
         4'b0_000: enc_3b4b_neg = 4'b1011;
         4'b0_001: enc_3b4b_neg = 4'b1001;
         4'b0_010: enc_3b4b_neg = 4'b0101;
         4'b0_011: enc_3b4b_neg = 4'b1100;
         4'b0_100: enc_3b4b_neg = 4'b1101;
         4'b0_101: enc_3b4b_neg = 4'b1010;
         4'b0_110: enc_3b4b_neg = 4'b0110;
         4'b0_111: enc_3b4b_neg = alt7 ? 4'b0111 : 4'b1110;
         4'b1_000: enc_3b4b_neg = 4'b1011;
         4'b1_001: enc_3b4b_neg = 4'b0110;
         4'b1_010: enc_3b4b_neg = 4'b1010;
         4'b1_011: enc_3b4b_neg = 4'b1100;
         4'b1_100: enc_3b4b_neg = 4'b1101;
         4'b1_101: enc_3b4b_neg = 4'b0101;
         4'b1_110: enc_3b4b_neg = 4'b1001;
         4'b1_111: enc_3b4b_neg = 4'b0111;
         default:  enc_3b4b_neg = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/encode_8b10b_wide_if.sv
// ---------------------------------------------------------------------------
// encode_8b10b_wide_if
// Byte-in / codeword-out bundle of the wide encoder.
//   in_valid, in_ctl[LANES], in_data[8*LANES], force_disparity, force_rd_neg
//   out_valid, out_codeword[10*LANES], out_rd_neg, out_ctl_err[LANES],
//   err_count[16]
// master = PCS framing side, slave = encoder.
// ---------------------------------------------------------------------------
interface encode_8b10b_wide_if #(parameter int LANES = 2);
   logic                  in_valid;
   logic [LANES-1:0]      in_ctl;
   logic [8*LANES-1:0]    in_data;
   logic                  force_disparity;
   logic                  force_rd_neg;
   logic                  out_valid;
   logic [10*LANES-1:0]   out_codeword;
   logic                  out_rd_neg;
   logic [LANES-1:0]      out_ctl_err;
   logic [15:0]           err_count;

   modport master (
      output in_valid, in_ctl, in_data, force_disparity, force_rd_neg,
      input  out_valid, out_codeword, out_rd_neg, out_ctl_err, err_count
   );

   modport slave (
      input  in_valid, in_ctl, in_data, force_disparity, force_rd_neg,
      output out_valid, out_codeword, out_rd_neg, out_ctl_err, err_count
   );
endinterface

// File: rtl/encode_8b10b_lane.sv
// ---------------------------------------------------------------------------
// encode_8b10b_lane
// Combinational single-byte 8b/10b encoder.
//   i_data[7:0]   HGFEDCBA byte
//   i_ctl         K flag
//   i_rd_in_neg   RD entering this lane (1 = negative)
//   o_code[9:0]   abcdei fghj, a = bit 9
//   o_rd_out_neg  RD leaving this lane
//   o_ctl_err     control byte has no K codeword (K28.5 emitted instead)
// ---------------------------------------------------------------------------
module encode_8b10b_lane
   import linecode_8b10b_pkg::*;
(
   input  logic [7:0] i_data,
   input  logic       i_ctl,
   input  logic       i_rd_in_neg,
   output logic [9:0] o_code,
   output logic       o_rd_out_neg,
   output logic       o_ctl_err
);

   logic [4:0] w_x;
   logic [2:0] w_y;
   logic       w_k28;
   logic [5:0] w_6b_neg;
   logic [5:0] w_6b;
   logic       w_6b_unbal;
   logic       w_rd6_neg;
   logic       w_alt7;
   logic [3:0] w_4b_neg;
   logic [3:0] w_4b;
   logic       w_4b_unbal;

   assign w_x   = i_data[4:0];
   assign w_y   = i_data[7:5];
   assign w_k28 = i_ctl & (w_x == 5'd28);

   // Kx.7 reuses the data 6b table; only K28 has its own 6b code
   assign w_6b_neg   = w_k28 ? 6'b001111 : enc_5b6b_neg(w_x);
   assign w_6b_unbal = ($countones(w_6b_neg) != 32'd3);
   // D.7 is balanced yet still alternates between 111000 and 000111
   assign w_6b       = (!i_rd_in_neg && (w_6b_unbal || (!w_k28 && (w_x == 5'd7))))
                       ? ~w_6b_neg : w_6b_neg;
   assign w_rd6_neg  = i_rd_in_neg ^ w_6b_unbal;

   // A7 avoids a run of five in e i f g h for these six x values
   assign w_alt7 = !i_ctl && (w_y == 3'd7) &&
                   (w_rd6_neg ? ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))
                              : ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14)));

   assign w_4b_neg   = enc_3b4b_neg(w_y, i_ctl, w_alt7);
   assign w_4b_unbal = ($countones(w_4b_neg) != 32'd2);
   // Every K 4b code alternates, as does the balanced data x.3 (1100/0011)
   assign w_4b       = (!w_rd6_neg && (i_ctl || w_4b_unbal || (w_y == 3'd3)))
                       ? ~w_4b_neg : w_4b_neg;

   assign o_ctl_err    = i_ctl & ~is_legal_k(i_data);
   assign o_code       = o_ctl_err ? (i_rd_in_neg ? K28_5_NEG : K28_5_POS) : {w_6b, w_4b};
   // K28.5 always flips RD
   assign o_rd_out_neg = o_ctl_err ? ~i_rd_in_neg : (w_rd6_neg ^ w_4b_unbal);

endmodule

// File: rtl/encode_8b10b_wide.sv
// ---------------------------------------------------------------------------
// encode_8b10b_wide
// LANES-byte-per-clock 8b/10b encoder with lane-chained running disparity.
//   clk, rst         core clock, synchronous active-high reset
//   bus (slave)      in_valid/in_ctl/in_data/force_disparity/force_rd_neg in,
//                    out_valid/out_codeword/out_rd_neg/out_ctl_err/err_count
// One clock latency, no backpressure. Lane 0 is transmitted first.
// ---------------------------------------------------------------------------
module encode_8b10b_wide
   import linecode_8b10b_pkg::*;
#(
   parameter int LANES          = 2,
   parameter bit INITIAL_RD_NEG = 1'b1
)
(
   input  logic                 clk,
   input  logic                 rst,
   encode_8b10b_wide_if.slave   bus
);

   logic                  r_rd_neg;
   logic                  r_out_valid;
   logic [10*LANES-1:0]   r_out_codeword;
   logic                  r_out_rd_neg;
   logic [LANES-1:0]      r_out_ctl_err;
   logic [15:0]           r_err_count;

   logic [LANES:0]        w_rd_chain;
   logic [10*LANES-1:0]   w_code;
   logic [LANES-1:0]      w_ctl_err;
   logic [2:0]            w_err_lanes;
   logic [16:0]           w_err_sum;
   logic [15:0]           w_err_next;

   assign w_rd_chain[0] = bus.force_disparity ? bus.force_rd_neg : r_rd_neg;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      encode_8b10b_lane u_lane (
         .i_data       (bus.in_data[8*g +: 8]),
         .i_ctl        (bus.in_ctl[g]),
         .i_rd_in_neg  (w_rd_chain[g]),
         .o_code       (w_code[10*g +: 10]),
         .o_rd_out_neg (w_rd_chain[g+1]),
         .o_ctl_err    (w_ctl_err[g])
      );
   end

   // Count illegal-K lanes this beat and add with saturation at 0xFFFF
   always_comb begin
      w_err_lanes = 3'd0;
      for (int i = 0; i < LANES; i++) begin
         w_err_lanes = w_err_lanes + {2'b00, w_ctl_err[i]};
      end
      w_err_sum  = {1'b0, r_err_count} + {14'd0, w_err_lanes};
      w_err_next = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
   end

   // RD register and output registers; idle beats hold everything but out_valid
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_neg       <= INITIAL_RD_NEG;
         r_out_valid    <= 1'b0;
         r_out_codeword <= '0;
         r_out_rd_neg   <= INITIAL_RD_NEG;
         r_out_ctl_err  <= '0;
         r_err_count    <= 16'd0;
      end else if (bus.in_valid) begin
         r_rd_neg       <= w_rd_chain[LANES];
         r_out_valid    <= 1'b1;
         r_out_codeword <= w_code;
         r_out_rd_neg   <= w_rd_chain[LANES];
         r_out_ctl_err  <= w_ctl_err;
         r_err_count    <= w_err_next;
      end else begin
         r_out_valid    <= 1'b0;
      end
   end

   assign bus.out_valid    = r_out_valid;
   assign bus.out_codeword = r_out_codeword;
   assign bus.out_rd_neg   = r_out_rd_neg;
   assign bus.out_ctl_err  = r_out_ctl_err;
   assign bus.err_count    = r_err_count;

endmodule
